// File: rtl/kanagawa_multi_fifo_ptrs_pkg.sv
// kanagawa_multi_fifo_ptrs_pkg: shared widths, slice helper and reset flag values
package kanagawa_multi_fifo_ptrs_pkg;
  localparam logic RST_FULL = 1'b1;
  localparam logic RST_ALMOST_FULL = 1'b1;
  localparam logic RST_EMPTY = 1'b1;
  localparam logic RST_ALMOST_EMPTY = 1'b1;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int usedw_lsb(input int c, input int cnt_w);
    return c * cnt_w;
  endfunction
endpackage

// File: rtl/kanagawa_fifo_chan_ptrs.sv
// kanagawa_fifo_chan_ptrs: one channel's pointers, count, flags and sticky errors
module kanagawa_fifo_chan_ptrs
  import kanagawa_multi_fifo_ptrs_pkg::*;
#(
  parameter int DEPTH = 27,
  parameter int AF_MARGIN = 5,
  parameter int AE_MARGIN = 3,
  localparam int LOG_DEPTH = $clog2(DEPTH),
  localparam int PTR_W = clog2_min1(DEPTH),
  localparam int CNT_W = LOG_DEPTH + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             flush,
  output logic [PTR_W-1:0] wrptr,
  output logic [PTR_W-1:0] rdptr,
  output logic [CNT_W-1:0] usedw,
  output logic             full,
  output logic             almost_full,
  output logic             empty,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_TH = CNT_W'(DEPTH - AF_MARGIN);
  localparam logic [CNT_W-1:0] AE_TH = CNT_W'(AE_MARGIN);
  logic wr_ok, rd_ok;
  logic [CNT_W-1:0] usedw_nxt;
  // acceptance uses the registered flags, so a read can free a full channel but not admit a write that cycle
  always_comb begin
    wr_ok = wr_en && !full && !flush;
    rd_ok = rd_en && !empty && !flush;
    usedw_nxt = flush ? '0 :
                (wr_ok && !rd_ok) ? usedw + CNT_W'(1) :
                (rd_ok && !wr_ok) ? usedw - CNT_W'(1) : usedw;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wrptr <= '0;
      rdptr <= '0;
      usedw <= '0;
      full <= RST_FULL;
      almost_full <= RST_ALMOST_FULL;
      empty <= RST_EMPTY;
      almost_empty <= RST_ALMOST_EMPTY;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wrptr <= flush ? '0 : !wr_ok ? wrptr : (wrptr == LAST) ? '0 : wrptr + PTR_W'(1);
      rdptr <= flush ? '0 : !rd_ok ? rdptr : (rdptr == LAST) ? '0 : rdptr + PTR_W'(1);
      usedw <= usedw_nxt;
      full <= usedw_nxt == FULL_CNT;
      almost_full <= usedw_nxt > AF_TH;
      empty <= usedw_nxt == '0;
      almost_empty <= usedw_nxt <= AE_TH;
      overflow <= !flush && (overflow || (wr_en && full));
      underflow <= !flush && (underflow || (rd_en && empty));
    end
  end
endmodule

// File: rtl/kanagawa_multi_fifo_ptrs.sv
// kanagawa_multi_fifo_ptrs: pointer/flag manager for several FIFOs sharing one 1W1R RAM
module kanagawa_multi_fifo_ptrs
  import kanagawa_multi_fifo_ptrs_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DEPTH = 27,
  parameter int ALMOST_FULL_MARGIN = 5,
  parameter int ALMOST_EMPTY_MARGIN = 3,
  localparam int LOG_DEPTH = $clog2(DEPTH),
  localparam int CNT_W = LOG_DEPTH + 1,
  localparam int CH_W = clog2_min1(NUM_CHANNELS),
  localparam int ADDR_W = clog2_min1(NUM_CHANNELS * DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wrreq_in,
  input  logic [CH_W-1:0]               wr_channel_in,
  output logic [ADDR_W-1:0]             wraddr_out,
  input  logic                          rdreq_in,
  input  logic [CH_W-1:0]               rd_channel_in,
  output logic [ADDR_W-1:0]             rdaddr_out,
  input  logic [NUM_CHANNELS-1:0]       flush_in,
  output logic [NUM_CHANNELS-1:0]       full_out,
  output logic [NUM_CHANNELS-1:0]       almost_full_out,
  output logic [NUM_CHANNELS-1:0]       empty_out,
  output logic [NUM_CHANNELS-1:0]       almost_empty_out,
  output logic [NUM_CHANNELS*CNT_W-1:0] usedw_out,
  output logic [NUM_CHANNELS-1:0]       overflow_out,
  output logic [NUM_CHANNELS-1:0]       underflow_out
);
  localparam int PTR_W = clog2_min1(DEPTH);
  localparam logic [CH_W:0] NCH = (CH_W + 1)'(NUM_CHANNELS);
  logic [PTR_W-1:0] wrptr [NUM_CHANNELS];
  logic [PTR_W-1:0] rdptr [NUM_CHANNELS];
  logic wr_in_range, rd_in_range;
  always_comb begin
    wr_in_range = {1'b0, wr_channel_in} < NCH;
    rd_in_range = {1'b0, rd_channel_in} < NCH;
    wraddr_out = wr_in_range ? ADDR_W'(wr_channel_in) * ADDR_W'(DEPTH) + ADDR_W'(wrptr[wr_channel_in]) : '0;
    rdaddr_out = rd_in_range ? ADDR_W'(rd_channel_in) * ADDR_W'(DEPTH) + ADDR_W'(rdptr[rd_channel_in]) : '0;
  end
  // an out-of-range index matches no channel, so the request is dropped by construction
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    kanagawa_fifo_chan_ptrs #(
      .DEPTH(DEPTH),
      .AF_MARGIN(ALMOST_FULL_MARGIN),
      .AE_MARGIN(ALMOST_EMPTY_MARGIN)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .wr_en(wrreq_in && wr_channel_in == CH_W'(c)),
      .rd_en(rdreq_in && rd_channel_in == CH_W'(c)),
      .flush(flush_in[c]),
      .wrptr(wrptr[c]),
      .rdptr(rdptr[c]),
      .usedw(usedw_out[usedw_lsb(c, CNT_W) +: CNT_W]),
      .full(full_out[c]),
      .almost_full(almost_full_out[c]),
      .empty(empty_out[c]),
      .almost_empty(almost_empty_out[c]),
      .overflow(overflow_out[c]),
      .underflow(underflow_out[c])
    );
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!wrreq_in || wr_in_range) else $error("write to out-of-range channel %0d", wr_channel_in);
      assert (!rdreq_in || rd_in_range) else $error("read from out-of-range channel %0d", rd_channel_in);
    end
  end
endmodule

// File: tb/tb_kanagawa_multi_fifo_ptrs.sv
// tb_kanagawa_multi_fifo_ptrs: directed vectors plus a short randomized model comparison
module tb_kanagawa_multi_fifo_ptrs;
  localparam int N = 4, D = 27, CW = 6, CHW = 2, AW = 7;
  logic clk = 1'b0, rst = 1'b1, wrreq_in = 1'b0, rdreq_in = 1'b0;
  logic [CHW-1:0] wr_channel_in = '0, rd_channel_in = '0;
  logic [AW-1:0] wraddr_out, rdaddr_out;
  logic [N-1:0] flush_in = '0;
  logic [N-1:0] full_out, almost_full_out, empty_out, almost_empty_out, overflow_out, underflow_out;
  logic [N*CW-1:0] usedw_out;
  int n_vec = 0, n_err = 0;
  int cnt [N], wp [N], rp [N];
  logic [N-1:0] fr, er, eaf, eae, ov, un;
  logic [N*CW-1:0] eu;
  always #5 clk = ~clk;
  kanagawa_multi_fifo_ptrs dut (
    .clk(clk), .rst(rst),
    .wrreq_in(wrreq_in), .wr_channel_in(wr_channel_in), .wraddr_out(wraddr_out),
    .rdreq_in(rdreq_in), .rd_channel_in(rd_channel_in), .rdaddr_out(rdaddr_out),
    .flush_in(flush_in), .full_out(full_out), .almost_full_out(almost_full_out),
    .empty_out(empty_out), .almost_empty_out(almost_empty_out), .usedw_out(usedw_out),
    .overflow_out(overflow_out), .underflow_out(underflow_out)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic w, input int wc, input logic r, input int rc, input logic [N-1:0] fl);
    wrreq_in = w;
    wr_channel_in = CHW'(wc);
    rdreq_in = r;
    rd_channel_in = CHW'(rc);
    flush_in = fl;
  endtask
  function automatic logic [CW-1:0] uw(input int c);
    return usedw_out[c*CW +: CW];
  endfunction
  task automatic model_step();
    logic w, r, wok, rok;
    for (int c = 0; c < N; c++) begin
      w = wrreq_in && int'(wr_channel_in) == c;
      r = rdreq_in && int'(rd_channel_in) == c;
      if (rst) begin
        cnt[c] = 0; wp[c] = 0; rp[c] = 0; ov[c] = 0; un[c] = 0; fr[c] = 1; er[c] = 1;
      end else if (flush_in[c]) begin
        cnt[c] = 0; wp[c] = 0; rp[c] = 0; ov[c] = 0; un[c] = 0; fr[c] = 0; er[c] = 1;
      end else begin
        wok = w && !fr[c];
        rok = r && !er[c];
        if (w && fr[c]) ov[c] = 1;
        if (r && er[c]) un[c] = 1;
        if (wok) wp[c] = (wp[c] + 1) % D;
        if (rok) rp[c] = (rp[c] + 1) % D;
        cnt[c] = cnt[c] + int'(wok) - int'(rok);
        fr[c] = cnt[c] == D;
        er[c] = cnt[c] == 0;
      end
      eaf[c] = rst ? 1'b1 : cnt[c] > D - 5;
      eae[c] = rst ? 1'b1 : cnt[c] <= 3;
      eu[c*CW +: CW] = CW'(cnt[c]);
    end
  endtask
  initial begin
    tick(); tick();
    chk("rst_full", full_out, 4'hF);
    chk("rst_afull", almost_full_out, 4'hF);
    chk("rst_empty", empty_out, 4'hF);
    chk("rst_aempty", almost_empty_out, 4'hF);
    chk("rst_usedw", usedw_out, 0);
    chk("rst_err", {overflow_out, underflow_out}, 0);
    rst = 1'b0;
    tick();
    chk("rel_full", full_out, 0);
    chk("rel_afull", almost_full_out, 0);
    chk("rel_empty", empty_out, 4'hF);
    chk("rel_aempty", almost_empty_out, 4'hF);
    for (int i = 0; i < D; i++) begin
      drive(1, 2, 0, 0, 0); #1;
      chk("fill_wraddr", wraddr_out, 54 + i);
      tick();
      chk("fill_usedw", uw(2), i + 1);
      chk("fill_afull", almost_full_out[2], (i + 1) > 22);
      chk("fill_full", full_out[2], (i + 1) == D);
    end
    drive(1, 2, 0, 0, 0); #1;
    chk("wrap_wraddr", wraddr_out, 54);
    tick();
    chk("ovf_usedw", uw(2), 27);
    chk("ovf_set", overflow_out, 4'b0100);
    chk("ovf_full", full_out[2], 1);
    for (int i = 0; i < D; i++) begin
      drive(0, 0, 1, 2, 0); #1;
      chk("drain_rdaddr", rdaddr_out, 54 + i);
      tick();
      chk("drain_usedw", uw(2), 26 - i);
      chk("drain_aempty", almost_empty_out[2], (26 - i) <= 3);
      chk("drain_empty", empty_out[2], (26 - i) == 0);
    end
    drive(0, 0, 1, 2, 0); #1;
    chk("wrap_rdaddr", rdaddr_out, 54);
    tick();
    chk("unf_set", underflow_out, 4'b0100);
    chk("unf_usedw", uw(2), 0);
    chk("ovf_sticky", overflow_out, 4'b0100);
    for (int i = 0; i < D; i++) begin
      drive(1, 2, 0, 0, 0); #1;
      chk("refill_wraddr", wraddr_out, 54 + i);
      tick();
    end
    chk("refill_full", full_out[2], 1);
    for (int i = 0; i < D; i++) begin
      drive(0, 0, 1, 2, 0); #1;
      chk("redrain_rdaddr", rdaddr_out, 54 + i);
      tick();
    end
    drive(0, 2, 0, 2, 0); #1;
    chk("wrap2_wraddr", wraddr_out, 54);
    chk("wrap2_rdaddr", rdaddr_out, 54);
    chk("redrain_empty", empty_out, 4'hF);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 0, 0);
      tick();
    end
    drive(1, 1, 1, 1, 0); #1;
    chk("sim_wraddr0", wraddr_out, 32);
    chk("sim_rdaddr0", rdaddr_out, 27);
    tick();
    chk("sim_usedw", uw(1), 5);
    drive(0, 1, 0, 1, 0); #1;
    chk("sim_wraddr1", wraddr_out, 33);
    chk("sim_rdaddr1", rdaddr_out, 28);
    for (int i = 0; i < 2; i++) begin
      drive(1, 3, 0, 0, 0);
      tick();
    end
    drive(1, 0, 1, 3, 0); #1;
    chk("x_wraddr", wraddr_out, 0);
    chk("x_rdaddr", rdaddr_out, 81);
    tick();
    chk("x_usedw0", uw(0), 1);
    chk("x_usedw3", uw(3), 1);
    chk("x_usedw1", uw(1), 5);
    for (int i = 0; i < 26; i++) begin
      drive(1, 0, 0, 0, 0);
      tick();
    end
    chk("fl_prefull", full_out[0], 1);
    drive(1, 0, 0, 0, 0);
    tick();
    chk("fl_preovf", overflow_out[0], 1);
    drive(1, 0, 0, 0, 4'b0001);
    tick();
    chk("fl_usedw0", uw(0), 0);
    chk("fl_empty0", empty_out[0], 1);
    chk("fl_full0", full_out[0], 0);
    chk("fl_afull0", almost_full_out[0], 0);
    chk("fl_ovf", overflow_out, 4'b0100);
    chk("fl_unf", underflow_out, 4'b0100);
    chk("fl_usedw1", uw(1), 5);
    chk("fl_usedw3", uw(3), 1);
    drive(0, 0, 0, 0, 0); #1;
    chk("fl_wraddr", wraddr_out, 0);
    chk("fl_rdaddr", rdaddr_out, 0);
    drive(1, 1, 1, 3, 0);
    rst = 1'b1;
    tick();
    chk("mid_rst_full", full_out, 4'hF);
    chk("mid_rst_empty", empty_out, 4'hF);
    chk("mid_rst_usedw", usedw_out, 0);
    chk("mid_rst_err", {overflow_out, underflow_out}, 0);
    for (int k = 0; k < 100; k++) begin
      rst = (k == 0) || ($urandom_range(0, 39) == 0);
      wrreq_in = $urandom_range(0, 9) < 7;
      wr_channel_in = CHW'($urandom_range(0, 1) + (k / 50) * 2);
      rdreq_in = $urandom_range(0, 9) < 3;
      rd_channel_in = CHW'($urandom_range(0, 3));
      for (int c = 0; c < N; c++) flush_in[c] = $urandom_range(0, 29) == 0;
      #1;
      chk("rnd_wraddr", wraddr_out, int'(wr_channel_in) * D + wp[wr_channel_in]);
      chk("rnd_rdaddr", rdaddr_out, int'(rd_channel_in) * D + rp[rd_channel_in]);
      model_step();
      tick();
      chk("rnd_full", full_out, fr);
      chk("rnd_empty", empty_out, er);
      chk("rnd_afull", almost_full_out, eaf);
      chk("rnd_aempty", almost_empty_out, eae);
      chk("rnd_usedw", usedw_out, eu);
      chk("rnd_ovf", overflow_out, ov);
      chk("rnd_unf", underflow_out, un);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
